div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Shares the single iterative 32-bit `div` core among N_REQ requesters, e.g. per-hart M-extension issue slots.
- Grants requests round-robin and decodes the RISC-V DIV/DIVU/REM/REMU operations.
- Bypasses divide-by-zero and signed overflow without using the core.
- Applies the RISC-V remainder sign rule and holds each result until the owning requester accepts it.
- Sits between the execute stage(s) and the `div` core, which it instantiates.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- TAG_W, 5, width of the opaque tag returned with the result (e.g. rd index).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard the in-flight or pending operation
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept
- req_op  in  2*N_REQ  per requester: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- req_a  in  32*N_REQ  dividend (rs1), requester i at [32i+31:32i]
- req_b  in  32*N_REQ  divisor (rs2)
- req_tag  in  TAG_W*N_REQ  tag
- rsp_valid  out  N_REQ  one-hot result valid, bit = owning requester
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_data  out  32  result
- rsp_tag  out  TAG_W  tag of the result
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state IDLE; rsp_valid=0, rsp_data=0, rsp_tag=0, req_ready=0.
  - round-robin pointer = 0; the `div` core is reset by the same reset.
- Single outstanding operation. FSM states: IDLE, START, BUSY, DRAIN, RESP.
- IDLE, arbitration and accept:
  - Round-robin grant among asserted req_valid, starting at the pointer.
  - req_ready is high only for the granted index, and only in IDLE with flush=0.
  - On accept, latch op/a/b/tag/owner and set the pointer to owner+1 (mod N_REQ).
- IDLE, next state:
  - If b==0, result = (DIV/DIVU) 0xFFFFFFFF, (REM/REMU) a; go to RESP.
  - If signed op and a==0x80000000 and b==0xFFFFFFFF, result = (DIV) 0x80000000, (REM) 0; go to RESP.
  - Otherwise go to START.
- START: drive the core with kick=1, unsigned_flag=op[0], dividend=a, divider=b; go to BUSY. The core is guaranteed ready here.
- BUSY: on core ready=1, capture the result and go to RESP.
  - Quotient for DIV/DIVU = core quotient.
  - Remainder fixup: core remainder is signed by (a31 xor b31); RISC-V requires sign of a.
  - rm = (signed && a31^b31) ? -core_rem : core_rem.
  - rem = (signed && a31) ? -rm : rm (REMU: core_rem unchanged).
- RESP: rsp_valid[owner]=1 with rsp_data/rsp_tag stable. Leave to IDLE when rsp_ready[owner]=1. No new accept in the same cycle.
- Latency, accept cycle T:
  - Normal op: rsp_valid first at T+35 (START T+1, core busy T+2..T+33, ready seen T+34).
  - Bypass op: rsp_valid at T+1.
- flush:
  - IDLE or RESP: go to IDLE, rsp_valid drops next cycle; the result is lost.
  - START: no kick, go to IDLE.
  - BUSY: go to DRAIN; DRAIN waits for core ready, then goes to IDLE with no response.
  - Flush has priority over accept and over rsp_ready.
- req_valid while not IDLE: ignored, req_ready=0. Requesters hold their request.
- Reset mid-operation: immediate IDLE, core reset, no response.

Decomposition:
- Package div_sched_pkg:
  - typedef div_op_t (enum DIV/DIVU/REM/REMU)
  - typedef state_t
  - constants DIV_BY_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000
- Sub-modules:
  - Existing `div` core, instantiated once.
  - Round-robin arbiter as rr_arb (N parameter; one-hot grant; pointer update on accept).

Test Plan:
- Req0 DIV a=-7, b=2, tag 3 -> rsp_valid[0] at T+35, data 0xFFFFFFFD (-3), tag 3. REM same operands -> 0xFFFFFFFF (-1).
- REM a=-7, b=-2 -> 0xFFFFFFFF (-1); REM a=7, b=-2 -> 1; REMU a=0xFFFFFFF9, b=2 -> 1; DIVU same -> 0x7FFFFFFC.
- DIV a=5, b=0 -> data 0xFFFFFFFF at T+1. REM a=5, b=0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0. Core kick never asserted in these cases.
- Both requesters held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. A held rsp_ready=0 keeps rsp_valid/data stable and blocks further accepts.
- flush 10 cycles after kick -> DRAIN until core ready, no rsp_valid. A next request accepted afterwards returns the correct result.
- Reset asserted in BUSY -> next cycle IDLE, rsp_valid=0. A new DIVU 100/7 -> 14 at T+35.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and constants for the divider scheduler.
//   div_op_t      - RISC-V M-extension divide ops, encoded as funct3[1:0]
//   state_t       - scheduler FSM state encoding, with S_* constants
//   DIV_BY_ZERO_Q - quotient returned for a zero divisor
//   INT_MIN       - most negative 32-bit value (signed-overflow dividend)
package div_sched_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_BUSY  = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_RESP  = 3'd4;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic op_is_rem(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_signed(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/div.sv
// div: iterative 32-bit restoring divider, one quotient bit per cycle.
//   clk, reset     - clock, synchronous active-high reset
//   kick           - start a division (honoured only while ready=1)
//   unsigned_flag  - 1: unsigned operands, 0: two's-complement operands
//   dividend       - numerator
//   divider        - denominator (must be non-zero)
//   quotient       - signed by (dividend31 ^ divider31) for signed ops
//   remainder      - carries the same sign as the quotient (not the dividend)
//   ready          - idle / result valid; low for 32 cycles after kick
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic        kick,
  input  logic        unsigned_flag,
  input  logic [31:0] dividend,
  input  logic [31:0] divider,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        ready
);

  logic        ready_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic        neg_q;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        ge;
  logic        start;

  assign start = kick && ready_q;
  assign a_neg = !unsigned_flag && dividend[31];
  assign b_neg = !unsigned_flag && divider[31];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divider : divider;

  // Partial remainder shifted left by one with the next dividend bit appended.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign ge     = !diff[33];

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else if (start) begin
      ready_q <= 1'b0;
      cnt_q   <= 5'd31;
    end else if (!ready_q) begin
      if (cnt_q == 5'd0) ready_q <= 1'b1;
      else cnt_q <= cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      quo_q <= a_mag;
      rem_q <= '0;
      dvs_q <= b_mag;
      neg_q <= a_neg ^ b_neg;
    end else if (!ready_q) begin
      rem_q <= ge ? diff[31:0] : rem_sh[31:0];
      quo_q <= {quo_q[30:0], ge};
    end
  end

  assign quotient  = neg_q ? -quo_q : quo_q;
  assign remainder = neg_q ? -rem_q : rem_q;
  assign ready     = ready_q;

endmodule

// File: rtl/div_sched_rr_arb.sv
// rr_arb: round-robin arbiter with a registered priority pointer.
//   clk, reset - clock, synchronous active-high reset (pointer -> 0)
//   req_i      - request vector
//   accept_i   - the current grant is taken; pointer moves past the winner
//   grant_o    - one-hot grant, first request at or after the pointer
module rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  // First pass covers indices at/above the pointer, second pass wraps around.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_q))) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        ptr_d      = PW'((i + 1) % N);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        ptr_d      = PW'((i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else if (accept_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/div_sched.sv
// div_sched: shares one iterative div core among N_REQ requesters.
//   clk, reset - clock, synchronous active-high reset (also resets the core)
//   flush      - abandon the in-flight or pending operation
//   req_*      - per-requester valid/ready handshake with op, a, b and tag
//                (requester i occupies slice i of each packed bus)
//   rsp_valid  - one-hot result valid for the owning requester
//   rsp_ready  - per-requester result accept
//   rsp_data   - quotient/remainder; rsp_tag - tag returned with it
//   busy       - scheduler not idle
// Zero divisors and signed INT_MIN/-1 are resolved without the core.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [32*N_REQ-1:0]    req_a,
  input  logic [32*N_REQ-1:0]    req_b,
  input  logic [TAG_W*N_REQ-1:0] req_tag,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy
);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   owner_q, owner_d;
  div_op_t            op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        data_q, data_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [N_REQ-1:0]   grant;
  logic               accept;
  logic [1:0]         sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [TAG_W-1:0]   sel_tag;

  logic               core_kick;
  logic               core_ready;
  logic [31:0]        core_quo;
  logic [31:0]        core_rem;

  // The core signs its remainder like the quotient; RISC-V wants the
  // dividend's sign, so first take the magnitude, then apply a's sign.
  function automatic logic [31:0] fix_rem(input div_op_t op, input logic a31,
                                          input logic b31, input logic [31:0] r);
    logic [31:0] rm;
    rm = (op_is_signed(op) && (a31 ^ b31)) ? -r : r;
    return (op_is_signed(op) && a31) ? -rm : rm;
  endfunction

  rr_arb #(.N(N_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  div u_div (
    .clk           (clk),
    .reset         (reset),
    .kick          (core_kick),
    .unsigned_flag (op_q[0]),
    .dividend      (a_q),
    .divider       (b_q),
    .quotient      (core_quo),
    .remainder     (core_rem),
    .ready         (core_ready)
  );

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op  = req_op[2*i +: 2];
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_tag = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign accept    = (state_q == S_IDLE) && !flush && (|grant);
  assign req_ready = ((state_q == S_IDLE) && !flush) ? grant : '0;
  assign rsp_valid = (state_q == S_RESP) ? owner_q : '0;
  assign rsp_data  = data_q;
  assign rsp_tag   = tag_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    tag_d     = tag_q;
    core_kick = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = grant;
          op_d    = div_op_t'(sel_op);
          a_d     = sel_a;
          b_d     = sel_b;
          tag_d   = sel_tag;
          if (sel_b == 32'd0) begin
            data_d  = op_is_rem(div_op_t'(sel_op)) ? sel_a : DIV_BY_ZERO_Q;
            state_d = S_RESP;
          end else if (op_is_signed(div_op_t'(sel_op)) && (sel_a == INT_MIN) &&
                       (sel_b == 32'hFFFF_FFFF)) begin
            data_d  = op_is_rem(div_op_t'(sel_op)) ? 32'd0 : INT_MIN;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          core_kick = 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else if (core_ready) begin
          data_d  = op_is_rem(op_q) ? fix_rem(op_q, a_q[31], b_q[31], core_rem)
                                    : core_quo;
          state_d = S_RESP;
        end
      end
      // Core cannot be aborted; wait it out so it is ready for the next kick.
      S_DRAIN: begin
        if (core_ready) state_d = S_IDLE;
      end
      S_RESP: begin
        if (flush || (|(rsp_ready & owner_q))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed, table-driven bench for div_sched (N_REQ=2, TAG_W=5).
module tb_div_sched;

  localparam int N_REQ = 2;
  localparam int TAG_W = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [32*N_REQ-1:0]    req_a;
  logic [32*N_REQ-1:0]    req_b;
  logic [TAG_W*N_REQ-1:0] req_tag;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [31:0]            rsp_data;
  logic [TAG_W-1:0]       rsp_tag;
  logic                   busy;

  div_sched #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int kick_cnt = 0;

  always @(posedge clk) if (dut.core_kick) kick_cnt <= kick_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
    req_op[2*idx +: 2]   = op;
    req_a[32*idx +: 32]  = a;
    req_b[32*idx +: 32]  = b;
    req_tag[5*idx +: 5]  = tag;
    req_valid[idx]       = 1'b1;
  endtask

  // Called right after a negedge: waits (bounded) until req_ready[idx] is seen.
  task automatic wait_ready(input int idx, output bit ok);
    int w;
    w = 0;
    #1;
    while (!req_ready[idx] && w < 50) begin
      @(negedge clk); #1;
      w++;
    end
    ok = req_ready[idx];
  endtask

  // Issue one op, measure cycles from accept to rsp_valid, then consume it.
  task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        output logic [31:0] d, output logic [4:0] t,
                        output logic [1:0] v, output int lat);
    bit ok;
    @(negedge clk);
    set_req(idx, op, a, b, tag);
    wait_ready(idx, ok);
    if (!ok) begin
      req_valid[idx] = 1'b0;
      d = 'x; t = 'x; v = 'x; lat = -1;
      return;
    end
    @(negedge clk);
    req_valid[idx] = 1'b0;
    lat = 1;
    #1;
    while (rsp_valid == '0 && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    d = rsp_data;
    t = rsp_tag;
    v = rsp_valid;
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  t;
    logic [1:0]  v;
    logic [31:0] hold_d;
    int          lat;
    int          k0;
    int          ng;
    int          gl[4];
    bit          ok;
    bit          seen;

    vecs[0]  = '{0, 2'b00, 32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFD, 35};
    vecs[1]  = '{0, 2'b10, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFF, 35};
    vecs[2]  = '{1, 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd5,  32'hFFFF_FFFF, 35};
    vecs[3]  = '{1, 2'b10, 32'd7,         32'hFFFF_FFFE, 5'd6,  32'd1,         35};
    vecs[4]  = '{0, 2'b11, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'd1,         35};
    vecs[5]  = '{1, 2'b01, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'h7FFF_FFFC, 35};
    vecs[6]  = '{0, 2'b00, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    vecs[7]  = '{1, 2'b10, 32'd5,         32'd0,         5'd10, 32'd5,         1};
    vecs[8]  = '{0, 2'b01, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{1, 2'b11, 32'd5,         32'd0,         5'd12, 32'd5,         1};
    vecs[10] = '{0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
    vecs[11] = '{1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1};
    vecs[12] = '{0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         35};
    vecs[13] = '{1, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 35};
    vecs[14] = '{0, 2'b00, 32'd100,       32'hFFFF_FFF9, 5'd17, 32'hFFFF_FFF2, 35};
    vecs[15] = '{1, 2'b10, 32'd100,       32'hFFFF_FFF9, 5'd18, 32'd2,         35};

    reset = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data",  rsp_data, 32'd0);
    check("reset_rsp_tag",   32'(rsp_tag), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_busy",      32'(busy), 32'd0);
    reset = 1'b0;

    // Directed single-op table
    for (int i = 0; i < 16; i++) begin
      k0 = kick_cnt;
      run_op(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, d, t, v, lat);
      check($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_data", i),  d, vecs[i].exp);
      check($sformatf("vec%0d_tag", i),   32'(t), 32'(vecs[i].tag));
      check($sformatf("vec%0d_valid", i), 32'(v), 32'(2'b01 << vecs[i].idx));
      check($sformatf("vec%0d_kicks", i), 32'(kick_cnt - k0), (vecs[i].lat == 35) ? 32'd1 : 32'd0);
    end

    // Round-robin with both requesters held valid and rsp_ready high
    @(negedge clk);
    set_req(0, 2'b10, 32'h11, 32'd0, 5'd1);
    set_req(1, 2'b10, 32'h22, 32'd0, 5'd2);
    rsp_ready = 2'b11;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk); #1;
      if (rsp_valid == 2'b01) check("rr_data0", rsp_data, 32'h11);
      else if (rsp_valid == 2'b10) check("rr_data1", rsp_data, 32'h22);
      else if (rsp_valid != 2'b00) check("rr_onehot", 32'(rsp_valid), 32'd1);
      if (req_ready != '0) begin
        gl[ng] = (req_ready == 2'b10) ? 1 : 0;
        ng++;
      end
    end
    check("rr_grants", 32'(ng), 32'd4);
    for (int k = 1; k < 4; k++) check($sformatf("rr_alt%0d", k), 32'(gl[k]), 32'(gl[k-1] == 0));
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rsp_ready = '0;

    // Held rsp_ready=0 keeps the result stable and blocks other accepts
    @(negedge clk);
    set_req(0, 2'b10, 32'h55, 32'd0, 5'd20);
    wait_ready(0, ok);
    check("hold_accept", 32'(ok), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, 2'b00, 32'd1, 32'd1, 5'd21);
    #1;
    hold_d = rsp_data;
    check("hold_data", hold_d, 32'h55);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_stable", rsp_data, hold_d);
      check("hold_block", 32'(req_ready), 32'd0);
    end
    // Flush in RESP drops the result; flush also blocks the pending accept
    flush = 1'b1;
    @(negedge clk); #1;
    check("rflush_valid", 32'(rsp_valid), 32'd0);
    check("rflush_idle", 32'(busy), 32'd0);
    check("rflush_noready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("rflush_noaccept", 32'(busy), 32'd0);
    flush = 1'b0;
    req_valid = '0;

    // Flush while BUSY: drain the core, no response, next op correct
    @(negedge clk);
    set_req(0, 2'b00, 32'd1000, 32'd3, 5'd22);
    wait_ready(0, ok);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (dut.core_kick) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("flush_kick_seen", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_valid", 32'(rsp_valid), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 60 && busy; c++) begin
      @(negedge clk); #1;
      if (rsp_valid != '0) seen = 1'b1;
    end
    check("drain_done", 32'(busy), 32'd0);
    check("drain_no_rsp", 32'(seen), 32'd0);
    run_op(0, 2'b01, 32'd100, 32'd7, 5'd23, d, t, v, lat);
    check("postflush_lat", 32'(lat), 32'd35);
    check("postflush_data", d, 32'd14);
    check("postflush_tag", 32'(t), 32'd23);

    // Reset while BUSY
    @(negedge clk);
    set_req(1, 2'b00, 32'd50, 32'd7, 5'd25);
    wait_ready(1, ok);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_core_ready", 32'(dut.core_ready), 32'd1);
    run_op(1, 2'b01, 32'd100, 32'd7, 5'd24, d, t, v, lat);
    check("postrst_lat", 32'(lat), 32'd35);
    check("postrst_data", d, 32'd14);
    check("postrst_tag", 32'(t), 32'd24);
    check("postrst_valid", 32'(v), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
